// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default number format, frame
// geometry, packer state encoding and a format-legality helper.
package fft_pkg;

   localparam int unsigned DEF_BIT_WIDTH  = 32;
   localparam int unsigned DEF_DECIMAL_PT = 16;
   localparam int unsigned DEF_N_SAMPLES  = 8;

   // FILL: collecting samples into slots; FULL: frame presented to the FFT
   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } pack_state_e;

   // One frame at the default geometry; word k is sample k.
   typedef logic [DEF_N_SAMPLES-1:0][DEF_BIT_WIDTH-1:0] frame_t;

   // A narrow format can be widened losslessly when no fraction bits are lost
   // and the wide integer part is at least as large as the narrow one.
   function automatic bit legal_format(input int unsigned in_width,
                                       input int unsigned in_frac,
                                       input int unsigned bit_width,
                                       input int unsigned decimal_pt);
      return (decimal_pt >= in_frac) && (decimal_pt + in_width <= bit_width + in_frac);
   endfunction

endpackage

// File: rtl/fft_sample_widen.sv
// Combinational fixed-point widener: sign-extend the narrow sample, then
// realign its binary point by shifting left.
module fft_sample_widen
   import fft_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned IN_FRAC    = 15,
   parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int unsigned DECIMAL_PT = DEF_DECIMAL_PT
) (
   input  logic [IN_WIDTH-1:0]  narrow,
   output logic [BIT_WIDTH-1:0] wide
);

   if (!legal_format(IN_WIDTH, IN_FRAC, BIT_WIDTH, DECIMAL_PT)) begin : g_illegal_format
      $error("fft_sample_widen: format cannot be widened without overflow or rounding");
   end

   localparam int unsigned SHIFT = DECIMAL_PT - IN_FRAC;

   logic signed [IN_WIDTH-1:0]  narrow_s;
   logic signed [BIT_WIDTH-1:0] extended;

   // Sign-extend via a signed size cast, then move the binary point.
   always_comb begin
      narrow_s = narrow;
      extended = BIT_WIDTH'(narrow_s);
      wide     = extended << SHIFT;
   end

endmodule

// File: rtl/fft_sample_packer.sv
// Deserializing front-end for the FFT: widens incoming samples and packs
// N_SAMPLES of them into one frame presented on a val/rdy stream.
module fft_sample_packer
   import fft_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned IN_FRAC    = 15,
   parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int unsigned DECIMAL_PT = DEF_DECIMAL_PT,
   parameter int unsigned N_SAMPLES  = DEF_N_SAMPLES
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [IN_WIDTH-1:0]              recv_msg,
   input  logic                             recv_val,
   output logic                             recv_rdy,
   output logic [BIT_WIDTH*N_SAMPLES-1:0]   send_msg,
   output logic                             send_val,
   input  logic                             send_rdy,
   output logic [$clog2(N_SAMPLES+1)-1:0]   fill_level
);

   localparam int unsigned CW = $clog2(N_SAMPLES + 1);
   localparam int unsigned IW = $clog2(N_SAMPLES);

   if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_n_samples
      $error("fft_sample_packer: N_SAMPLES must be a power of two and at least 2");
   end

   pack_state_e                          state_q;
   logic [CW-1:0]                        count_q;
   logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] slot_q;

   logic [BIT_WIDTH-1:0] widened;
   logic                 in_fill;
   logic                 accept;
   logic [IW-1:0]        wr_idx;

   fft_sample_widen #(
      .IN_WIDTH   (IN_WIDTH),
      .IN_FRAC    (IN_FRAC),
      .BIT_WIDTH  (BIT_WIDTH),
      .DECIMAL_PT (DECIMAL_PT)
   ) u_widen (
      .narrow (recv_msg),
      .wide   (widened)
   );

   // Handshake outputs come straight from state; reset masks them because it is synchronous.
   always_comb begin
      in_fill    = (state_q == FILL);
      recv_rdy   = reset && (in_fill || send_rdy);
      send_val   = reset && !in_fill;
      fill_level = reset ? count_q : '0;
      send_msg   = slot_q;
      accept     = recv_val && recv_rdy;
      // A sample accepted while draining a full frame starts the next frame.
      wr_idx     = in_fill ? count_q[IW-1:0] : '0;
   end

   // Frame control: fill count and FILL/FULL state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FILL;
         count_q <= '0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (accept) begin
                  count_q <= count_q + CW'(1);
                  if (count_q == CW'(N_SAMPLES - 1)) begin
                     state_q <= FULL;
                  end
               end
            end
            FULL: begin
               if (send_rdy) begin
                  state_q <= FILL;
                  count_q <= recv_val ? CW'(1) : '0;
               end
            end
            default: begin
               state_q <= FILL;
               count_q <= '0;
            end
         endcase
      end
   end

   // Slot storage: each accepted sample lands in the next slot of the frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_q <= '0;
      end else if (accept) begin
         slot_q[wr_idx] <= widened;
      end
   end

   // A presented frame must stay put until the FFT takes it.
   a_frame_held : assert property (@(posedge clk) disable iff (!reset)
      (send_val && !send_rdy) |=> (send_val && $stable(send_msg)));

endmodule

// File: tb/tb_fft_sample_packer.sv
// Self-checking bench for fft_sample_packer: a queue-based model of the frame
// being assembled predicts every output each cycle; directed scenarios add
// hand-computed literal checks.
module tb_fft_sample_packer;

   localparam int N  = 8;
   localparam int BW = 32;

   logic            clk;
   logic            reset;
   logic [15:0]     recv_msg;
   logic            recv_val;
   logic            recv_rdy;
   logic [N*BW-1:0] send_msg;
   logic            send_val;
   logic            send_rdy;
   logic [3:0]      fill_level;

   int total = 0;
   int bad   = 0;

   // Model state: samples held in the frame under construction, in arrival order.
   logic [31:0] held[$];
   int          frames      = 0;
   int          rdy_low_cnt = 0;
   logic [31:0] dut_slot0[$];

   fft_sample_packer dut (
      .clk        (clk),
      .reset      (reset),
      .recv_msg   (recv_msg),
      .recv_val   (recv_val),
      .recv_rdy   (recv_rdy),
      .send_msg   (send_msg),
      .send_val   (send_val),
      .send_rdy   (send_rdy),
      .fill_level (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Q1.15 -> Q16.16: value * 2 in a 32-bit signed container.
   function automatic logic [31:0] widen(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      return 32'(v * 2);
   endfunction

   // Per-cycle compare against the model, then advance the model by this edge's transfers.
   always @(negedge clk) begin
      int  n;
      bit  full;
      bit  exp_rdy;
      if (!reset) begin
         check("rst_recv_rdy", recv_rdy, 0);
         check("rst_send_val", send_val, 0);
         check("rst_fill_level", fill_level, 0);
         held.delete();
      end else begin
         n       = held.size();
         full    = (n == N);
         exp_rdy = !full || send_rdy;
         check("recv_rdy", recv_rdy, exp_rdy);
         check("send_val", send_val, full);
         check("fill_level", fill_level, n);
         for (int k = 0; k < n; k++) begin
            check($sformatf("slot%0d", k), send_msg[k*BW +: BW], held[k]);
         end
         if (!recv_rdy) rdy_low_cnt++;
         if (full && send_rdy) begin
            frames++;
            dut_slot0.push_back(send_msg[31:0]);
            held.delete();
         end
         if (exp_rdy && recv_val) held.push_back(widen(recv_msg));
      end
   end

   task automatic push(input logic [15:0] x, input logic rdy);
      recv_val = 1'b1;
      recv_msg = x;
      send_rdy = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles, input logic rdy);
      recv_val = 1'b0;
      send_rdy = rdy;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [15:0]     lit_in[8]  = '{16'h8000, 16'h4000, 16'h7FFF, 16'h0001,
                                   16'h0000, 16'hC000, 16'hFFFF, 16'h2000};
   logic [31:0]     lit_out[8] = '{32'hFFFF0000, 32'h00008000, 32'h0000FFFE, 32'h00000002,
                                   32'h00000000, 32'hFFFF8000, 32'hFFFFFFFE, 32'h00004000};
   logic [N*BW-1:0] exp_frame;
   logic [N*BW-1:0] held_frame;
   logic [15:0]     b2b[24];
   logic [15:0]     first_new;
   int              f0;
   int              r0;

   initial begin
      reset    = 1'b0;
      recv_val = 1'b0;
      recv_msg = '0;
      send_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2, 1'b0);

      // Widening: literal frame exactly one cycle after the 8th accept
      for (int i = 0; i < 8; i++) push(lit_in[i], 1'b1);
      recv_val = 1'b0;
      for (int k = 0; k < N; k++) exp_frame[k*BW +: BW] = lit_out[k];
      @(negedge clk);
      check("widen_send_val", send_val, 1);
      check("widen_frame", send_msg, exp_frame);
      @(posedge clk);
      #1;
      idle(1, 1'b0);

      // Backpressure: full frame held for 10 stalled cycles, then one transfer
      for (int i = 0; i < 8; i++) push(16'(($urandom)), 1'b0);
      recv_val   = 1'b1;
      recv_msg   = 16'h5555;
      held_frame = send_msg;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_send_val", send_val, 1);
         check("bp_stable", send_msg, held_frame);
         check("bp_recv_rdy", recv_rdy, 0);
         check("bp_fill", fill_level, 8);
         @(posedge clk);
         #1;
      end
      f0 = frames;
      idle(1, 1'b1);
      idle(3, 1'b0);
      check("bp_one_frame", frames - f0, 1);

      // Back-to-back streaming, no bubbles
      f0 = frames;
      r0 = rdy_low_cnt;
      for (int i = 0; i < 24; i++) b2b[i] = 16'($urandom);
      for (int i = 0; i < 24; i++) push(b2b[i], 1'b1);
      idle(2, 1'b1);
      check("b2b_frames", frames - f0, 3);
      check("b2b_no_idle_rdy", rdy_low_cnt - r0, 0);
      check("b2b_idx8_slot0", dut_slot0[f0 + 1], widen(b2b[8]));

      // Simultaneous drain and accept
      for (int i = 0; i < 8; i++) push(16'($urandom), 1'b0);
      f0 = frames;
      push(16'h1234, 1'b1);
      recv_val = 1'b0;
      send_rdy = 1'b0;
      @(negedge clk);
      check("sim_frame_sent", frames - f0, 1);
      check("sim_fill", fill_level, 1);
      check("sim_slot0", send_msg[31:0], 32'h00002468);
      check("sim_send_val", send_val, 0);
      @(posedge clk);
      #1;

      // Reset mid-frame discards the partial frame
      for (int i = 0; i < 4; i++) push(16'($urandom), 1'b0);
      recv_val = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("midrst_fill", fill_level, 0);
      check("midrst_recv_rdy", recv_rdy, 0);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      f0        = frames;
      first_new = 16'h0ACE;
      push(first_new, 1'b1);
      for (int i = 1; i < 8; i++) push(16'($urandom), 1'b1);
      idle(2, 1'b1);
      check("midrst_frames", frames - f0, 1);
      check("midrst_slot0", dut_slot0[f0], 32'h0000159C);

      // Random val/rdy against the model
      f0 = frames;
      for (int c = 0; c < 3000; c++) begin
         recv_val = ($urandom_range(0, 3) != 0);
         send_rdy = ($urandom_range(0, 2) != 0);
         recv_msg = 16'($urandom);
         @(posedge clk);
         #1;
      end
      idle(3, 1'b1);
      check("rand_progress", (frames - f0) > 100, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
